// File: rtl/mmio_arbiter.sv
// Two-requester arbiter and sequencer for the shared MMIO port.
// Each granted access goes through ISSUE and, for reads, RDATA; long stalls are aborted.
module mmio_arbiter #(
    parameter bit PRIO_FIXED = 1'b0,
    parameter int TIMEOUT    = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0,
    input  logic        we0,
    input  logic        bsel0,
    input  logic        ben0,
    input  logic [15:0] addr0,
    input  logic [15:0] wdata0,
    input  logic        req1,
    input  logic        we1,
    input  logic        bsel1,
    input  logic        ben1,
    input  logic [15:0] addr1,
    input  logic [15:0] wdata1,
    output logic        ack0,
    output logic        err0,
    output logic [15:0] rdata0,
    output logic        ack1,
    output logic        err1,
    output logic [15:0] rdata1,
    output logic        m_en,
    output logic        m_we,
    output logic        m_bsel,
    output logic        m_ben,
    output logic [15:0] m_addr,
    output logic [15:0] m_wdata,
    input  logic [15:0] m_rdata,
    input  logic        m_wait
);

    typedef enum logic [1:0] {IDLE, ISSUE, RDATA} state_t;

    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

    state_t      state_q, state_d;
    logic        gnt_q, gnt_d;
    logic        last_q, last_d;
    logic [7:0]  cnt_q, cnt_d;

    logic        win;
    logic        ack_o, err_o;
    logic [15:0] rdata_o;

    logic        o_we, o_bsel, o_ben;
    logic [15:0] o_addr, o_wdata;

    assign o_we    = gnt_q ? we1    : we0;
    assign o_bsel  = gnt_q ? bsel1  : bsel0;
    assign o_ben   = gnt_q ? ben1   : ben0;
    assign o_addr  = gnt_q ? addr1  : addr0;
    assign o_wdata = gnt_q ? wdata1 : wdata0;

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        win     = 1'b0;
        ack_o   = 1'b0;
        err_o   = 1'b0;
        rdata_o = 16'h0000;
        m_en    = 1'b0;
        m_we    = 1'b0;
        m_bsel  = 1'b0;
        m_ben   = 1'b0;
        m_addr  = 16'h0000;
        m_wdata = 16'h0000;

        case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    // Contention: fixed priority favours requester 0, otherwise alternate.
                    if (req0 && req1) win = PRIO_FIXED ? 1'b0 : ~last_q;
                    else              win = req1;
                    gnt_d   = win;
                    last_d  = win;
                    cnt_d   = 8'd0;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                m_en    = 1'b1;
                m_we    = o_we;
                m_bsel  = o_bsel;
                m_ben   = o_ben;
                m_addr  = o_addr;
                m_wdata = o_wdata;
                if (m_wait) begin
                    if (cnt_q == TIMEOUT_CNT) begin
                        m_en    = 1'b0;
                        ack_o   = 1'b1;
                        err_o   = 1'b1;
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end else if (o_we) begin
                    ack_o   = 1'b1;
                    state_d = IDLE;
                end else begin
                    state_d = RDATA;
                end
            end
            RDATA: begin
                // Address stays selected so the registered read data belongs to this access.
                m_addr  = o_addr;
                m_bsel  = o_bsel;
                ack_o   = 1'b1;
                rdata_o = m_rdata;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (rst) begin
            ack_o   = 1'b0;
            err_o   = 1'b0;
            rdata_o = 16'h0000;
            m_en    = 1'b0;
            m_we    = 1'b0;
            m_bsel  = 1'b0;
            m_ben   = 1'b0;
            m_addr  = 16'h0000;
            m_wdata = 16'h0000;
        end
    end

    assign ack0   = ack_o & ~gnt_q;
    assign ack1   = ack_o &  gnt_q;
    assign err0   = err_o & ~gnt_q;
    assign err1   = err_o &  gnt_q;
    assign rdata0 = gnt_q ? 16'h0000 : rdata_o;
    assign rdata1 = gnt_q ? rdata_o  : 16'h0000;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            gnt_q   <= 1'b0;
            last_q  <= 1'b1;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_mmio_arbiter.sv
// Directed bench for mmio_arbiter: a round-robin instance with a small MMIO model and
// a fixed-priority instance with a short timeout, both driven by the same requests.
module tb_mmio_arbiter;

    logic        clk, rst;
    logic        req0, we0, bsel0, ben0, req1, we1, bsel1, ben1;
    logic [15:0] addr0, wdata0, addr1, wdata1;

    logic        a_ack0, a_err0, a_ack1, a_err1, a_m_en, a_m_we, a_m_bsel, a_m_ben, m_wait_a;
    logic [15:0] a_rdata0, a_rdata1, a_m_addr, a_m_wdata, m_rdata_a;
    logic        b_ack0, b_err0, b_ack1, b_err1, b_m_en, b_m_we, b_m_bsel, b_m_ben, m_wait_b;
    logic [15:0] b_rdata0, b_rdata1, b_m_addr, b_m_wdata, m_rdata_b;

    logic [7:0]  led;
    logic [3:0]  sw;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic        owner;
        logic        err;
        logic        chk_rd;
        logic [15:0] rdata;
    } exp_t;
    exp_t sb[$];

    mmio_arbiter dut_a (
        .clk(clk), .rst(rst),
        .req0(req0), .we0(we0), .bsel0(bsel0), .ben0(ben0), .addr0(addr0), .wdata0(wdata0),
        .req1(req1), .we1(we1), .bsel1(bsel1), .ben1(ben1), .addr1(addr1), .wdata1(wdata1),
        .ack0(a_ack0), .err0(a_err0), .rdata0(a_rdata0),
        .ack1(a_ack1), .err1(a_err1), .rdata1(a_rdata1),
        .m_en(a_m_en), .m_we(a_m_we), .m_bsel(a_m_bsel), .m_ben(a_m_ben),
        .m_addr(a_m_addr), .m_wdata(a_m_wdata), .m_rdata(m_rdata_a), .m_wait(m_wait_a)
    );

    mmio_arbiter #(.PRIO_FIXED(1'b1), .TIMEOUT(4)) dut_b (
        .clk(clk), .rst(rst),
        .req0(req0), .we0(we0), .bsel0(bsel0), .ben0(ben0), .addr0(addr0), .wdata0(wdata0),
        .req1(req1), .we1(we1), .bsel1(bsel1), .ben1(ben1), .addr1(addr1), .wdata1(wdata1),
        .ack0(b_ack0), .err0(b_err0), .rdata0(b_rdata0),
        .ack1(b_ack1), .err1(b_err1), .rdata1(b_rdata1),
        .m_en(b_m_en), .m_we(b_m_we), .m_bsel(b_m_bsel), .m_ben(b_m_ben),
        .m_addr(b_m_addr), .m_wdata(b_m_wdata), .m_rdata(m_rdata_b), .m_wait(m_wait_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Minimal peripheral: LED register at 7f80, switches at 7f81, registered read data.
    always @(posedge clk) begin
        if (a_m_en && a_m_we && a_m_addr == 16'h7f80) led <= a_m_wdata[7:0];
        if (a_m_en) begin
            if (a_m_addr == 16'h7f80)      m_rdata_a <= {8'h00, led};
            else if (a_m_addr == 16'h7f81) m_rdata_a <= {12'h000, sw};
            else                           m_rdata_a <= 16'hdead;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic owner, input logic err, input logic chk_rd,
                            input logic [15:0] rdata);
        exp_t e;
        e.owner = owner; e.err = err; e.chk_rd = chk_rd; e.rdata = rdata;
        sb.push_back(e);
    endtask

    task automatic gap();
        req0 = 1'b0;
        req1 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor for the round-robin instance.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && (a_ack0 || a_ack1)) begin
            chk("a_ack_excl", {31'b0, a_ack0 & a_ack1}, 0);
            chk("a_sb_nonempty", {31'b0, sb.size() != 0}, 1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("a_owner", {31'b0, a_ack1}, {31'b0, e.owner});
                chk("a_err", {31'b0, e.owner ? a_err1 : a_err0}, {31'b0, e.err});
                chk("a_nonowner_rdata", {16'b0, e.owner ? a_rdata0 : a_rdata1}, 0);
                if (e.chk_rd) chk("a_rdata", {16'b0, e.owner ? a_rdata1 : a_rdata0}, {16'b0, e.rdata});
            end
        end
        if (!rst && (b_ack0 || b_ack1)) chk("b_ack_excl", {31'b0, b_ack0 & b_ack1}, 0);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int na0, na1, nb0, nb1;
        rst = 1'b1;
        req0 = 1'b1; we0 = 1'b1; bsel0 = 1'b0; ben0 = 1'b1; addr0 = 16'h7f80; wdata0 = 16'h0000;
        req1 = 1'b0; we1 = 1'b0; bsel1 = 1'b0; ben1 = 1'b1; addr1 = 16'h0000; wdata1 = 16'h0000;
        m_wait_a = 1'b0; m_wait_b = 1'b0; m_rdata_b = 16'h1234; sw = 4'b1010;
        led = 8'h00; m_rdata_a = 16'h0000;

        // Reset: outputs stay low even with a request pending
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_m_en", {31'b0, a_m_en}, 0);
        chk("rst_ack0", {31'b0, a_ack0}, 0);
        chk("rst_b_m_en", {31'b0, b_m_en}, 0);
        @(posedge clk); #1;
        rst = 1'b0; req0 = 1'b0;
        @(negedge clk);
        chk("post_rst_m_addr", {16'b0, a_m_addr}, 0);
        chk("post_rst_acks", {30'b0, a_ack0, a_ack1}, 0);
        @(posedge clk); #1;

        // Single write of the LED register
        req0 = 1'b1; we0 = 1'b1; addr0 = 16'h7f80; bsel0 = 1'b0; wdata0 = 16'h00a5;
        push_exp(1'b0, 1'b0, 1'b0, 16'h0000);
        @(negedge clk);
        chk("wr_T_m_en", {31'b0, a_m_en}, 0);
        @(negedge clk);
        chk("wr_T1_m_en", {31'b0, a_m_en}, 1);
        chk("wr_T1_m_addr", {16'b0, a_m_addr}, 32'h7f80);
        chk("wr_T1_m_we", {31'b0, a_m_we}, 1);
        chk("wr_T1_m_wdata", {16'b0, a_m_wdata}, 32'h00a5);
        chk("wr_T1_ack0", {31'b0, a_ack0}, 1);
        @(posedge clk); #1;
        gap();

        // Read back the LED register
        req0 = 1'b1; we0 = 1'b0; addr0 = 16'h7f80;
        push_exp(1'b0, 1'b0, 1'b1, 16'h00a5);
        @(negedge clk);
        @(negedge clk);
        chk("led_rd_T1_ack0", {31'b0, a_ack0}, 0);
        @(negedge clk);
        chk("led_rd_T2_ack0", {31'b0, a_ack0}, 1);
        chk("led_rd_T2_rdata0", {16'b0, a_rdata0}, 32'h00a5);
        @(posedge clk); #1;
        gap();

        // Single read of the switches by requester 1
        req1 = 1'b1; we1 = 1'b0; addr1 = 16'h7f81;
        push_exp(1'b1, 1'b0, 1'b1, 16'h000a);
        @(negedge clk);
        chk("rd_T_m_en", {31'b0, a_m_en}, 0);
        @(negedge clk);
        chk("rd_T1_m_en", {31'b0, a_m_en}, 1);
        chk("rd_T1_m_addr", {16'b0, a_m_addr}, 32'h7f81);
        chk("rd_T1_ack1", {31'b0, a_ack1}, 0);
        @(negedge clk);
        chk("rd_T2_m_en", {31'b0, a_m_en}, 0);
        chk("rd_T2_m_addr", {16'b0, a_m_addr}, 32'h7f81);
        chk("rd_T2_ack1", {31'b0, a_ack1}, 1);
        chk("rd_T2_rdata1", {16'b0, a_rdata1}, 32'h000a);
        @(posedge clk); #1;
        gap();

        // Contention with both requesters writing continuously
        req0 = 1'b1; we0 = 1'b1; addr0 = 16'h7f82; wdata0 = 16'h1111;
        req1 = 1'b1; we1 = 1'b1; addr1 = 16'h7f83; wdata1 = 16'h2222;
        push_exp(1'b0, 1'b0, 1'b0, 16'h0); push_exp(1'b1, 1'b0, 1'b0, 16'h0);
        push_exp(1'b0, 1'b0, 1'b0, 16'h0); push_exp(1'b1, 1'b0, 1'b0, 16'h0);
        na0 = 0; na1 = 0; nb0 = 0; nb1 = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            na0 += int'(a_ack0); na1 += int'(a_ack1);
            nb0 += int'(b_ack0); nb1 += int'(b_ack1);
        end
        @(posedge clk); #1;
        gap();
        chk("rr_acks0", na0, 2);
        chk("rr_acks1", na1, 2);
        chk("fixed_acks0", nb0, 4);
        chk("fixed_acks1", nb1, 0);

        // Write stalled for 5 cycles
        req0 = 1'b1; we0 = 1'b1; addr0 = 16'h7f90; wdata0 = 16'h0041;
        push_exp(1'b0, 1'b0, 1'b0, 16'h0);
        @(negedge clk);
        chk("stall_T_m_en", {31'b0, a_m_en}, 0);
        @(posedge clk); #1;
        m_wait_a = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_m_en", {31'b0, a_m_en}, 1);
            chk("stall_ack0", {31'b0, a_ack0}, 0);
        end
        @(posedge clk); #1;
        m_wait_a = 1'b0;
        @(negedge clk);
        chk("stall_end_m_en", {31'b0, a_m_en}, 1);
        chk("stall_end_m_addr", {16'b0, a_m_addr}, 32'h7f90);
        chk("stall_end_ack0", {31'b0, a_ack0}, 1);
        chk("stall_end_err0", {31'b0, a_err0}, 0);
        @(posedge clk); #1;
        gap();

        // Timeout on the TIMEOUT=4 instance, then a normal retry
        req0 = 1'b1; we0 = 1'b0; addr0 = 16'h7f81;
        m_wait_a = 1'b1; m_wait_b = 1'b1;
        push_exp(1'b0, 1'b0, 1'b1, 16'h000a);
        @(negedge clk);
        chk("to_T_m_en", {31'b0, b_m_en}, 0);
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            chk("to_stall_m_en", {31'b0, b_m_en}, 1);
            chk("to_stall_ack0", {31'b0, b_ack0}, 0);
        end
        @(negedge clk);
        chk("to_ack0", {31'b0, b_ack0}, 1);
        chk("to_err0", {31'b0, b_err0}, 1);
        chk("to_rdata0", {16'b0, b_rdata0}, 0);
        chk("to_m_en", {31'b0, b_m_en}, 0);
        chk("to_a_still_stalled", {31'b0, a_m_en}, 1);
        @(posedge clk); #1;
        m_wait_a = 1'b0; m_wait_b = 1'b0;
        @(negedge clk);
        chk("to_idle_m_en", {31'b0, b_m_en}, 0);
        @(negedge clk);
        chk("to_retry_m_en", {31'b0, b_m_en}, 1);
        @(posedge clk); #1;
        req0 = 1'b0;
        @(negedge clk);
        chk("to_retry_ack0", {31'b0, b_ack0}, 1);
        chk("to_retry_err0", {31'b0, b_err0}, 0);
        chk("to_retry_rdata0", {16'b0, b_rdata0}, 32'h1234);
        @(posedge clk); #1;
        gap();

        // Reset while in RDATA, then both request: requester 0 must win first
        req1 = 1'b1; we1 = 1'b0; addr1 = 16'h7f81;
        @(negedge clk);
        @(negedge clk);
        chk("rst_rd_T1_m_en", {31'b0, a_m_en}, 1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("rst_rd_ack1", {31'b0, a_ack1}, 0);
        chk("rst_rd_rdata1", {16'b0, a_rdata1}, 0);
        chk("rst_rd_m_addr", {16'b0, a_m_addr}, 0);
        chk("rst_rd_b_ack1", {31'b0, b_ack1}, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        req0 = 1'b1; we0 = 1'b1; addr0 = 16'h7f85; wdata0 = 16'h0001;
        req1 = 1'b1; we1 = 1'b1; addr1 = 16'h7f84; wdata1 = 16'h0002;
        push_exp(1'b0, 1'b0, 1'b0, 16'h0);
        push_exp(1'b1, 1'b0, 1'b0, 16'h0);
        @(negedge clk);
        chk("after_rst_m_en", {31'b0, a_m_en}, 0);
        chk("after_rst_ack1", {31'b0, a_ack1}, 0);
        @(negedge clk);
        chk("after_rst_first_ack0", {31'b0, a_ack0}, 1);
        @(posedge clk); #1;
        req0 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("after_rst_second_ack1", {31'b0, a_ack1}, 1);
        @(posedge clk); #1;
        gap();

        chk("sb_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
